// File: rtl/bias_pkg.sv
// Shared constants and saturating-add helper for the bias and requant stages.
package bias_pkg;

  localparam int unsigned BIAS_W = 18;

  localparam logic [BIAS_W-1:0] SAT_MAX = 18'h1FFFF;
  localparam logic [BIAS_W-1:0] SAT_MIN = 18'h20000;

  // Returns {sat, sum}; sat is set when the true sum fell outside the W-bit range.
  function automatic logic [BIAS_W:0] sat_add(input logic [BIAS_W-1:0] a,
                                              input logic [BIAS_W-1:0] b);
    logic [BIAS_W:0] s;
    s = {a[BIAS_W-1], a} + {b[BIAS_W-1], b};
    if (s[BIAS_W] != s[BIAS_W-1])
      return s[BIAS_W] ? {1'b1, SAT_MIN} : {1'b1, SAT_MAX};
    return {1'b0, s[BIAS_W-1:0]};
  endfunction

endpackage

// File: rtl/bias_lane_sat.sv
// One lane of combinational two's-complement add with clamp to the W-bit range.
module bias_lane_sat
  import bias_pkg::*;
#(
  parameter int unsigned W = BIAS_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         sat
);

  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic [W:0] s;

  always_comb begin
    s   = {a[W-1], a} + {b[W-1], b};
    sat = s[W] ^ s[W-1];
    sum = s[W-1:0];
    if (sat)
      sum = s[W] ? MINV : MAXV;
  end

endmodule

// File: rtl/bias_add_stage.sv
// Loadable per-channel bias add with saturation, two-stage valid/ready pipeline.
module bias_add_stage
  import bias_pkg::*;
#(
  parameter  int unsigned N_adder_tree = 16,
  parameter  int unsigned W            = BIAS_W,
  parameter  int unsigned N_GROUPS     = 8,
  localparam int unsigned GW           = $clog2(N_GROUPS),
  localparam int unsigned LW           = $clog2(N_adder_tree)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bias_wr_en,
  input  logic [GW-1:0]             bias_wr_group,
  input  logic [LW-1:0]             bias_wr_lane,
  input  logic [W-1:0]              bias_wr_data,
  input  logic                      grp_restart,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_adder_tree*W-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_adder_tree*W-1:0] out_data,
  output logic [N_adder_tree-1:0]   out_sat,
  output logic [GW-1:0]             out_group
);

  localparam logic [GW-1:0] GRP_LAST = GW'(N_GROUPS - 1);

  logic [W-1:0]              bias_mem [N_GROUPS][N_adder_tree];
  logic [GW-1:0]             grp;
  logic                      en;
  logic                      accept;

  logic                      s1_valid;
  logic [N_adder_tree*W-1:0] s1_data;
  logic [N_adder_tree*W-1:0] s1_bias;
  logic [GW-1:0]             s1_grp;

  logic [N_adder_tree*W-1:0] sum;
  logic [N_adder_tree-1:0]   sat;

  // Both stages share one enable, so a stall freezes the whole pipe.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign accept   = in_valid & en;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned g = 0; g < N_GROUPS; g++)
        for (int unsigned l = 0; l < N_adder_tree; l++)
          bias_mem[g][l] <= '0;
    end else if (bias_wr_en) begin
      bias_mem[bias_wr_group][bias_wr_lane] <= bias_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || grp_restart)
      grp <= '0;
    else if (accept)
      grp <= (grp == GRP_LAST) ? '0 : grp + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_bias  <= '0;
      s1_grp   <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_grp  <= grp;
        for (int unsigned l = 0; l < N_adder_tree; l++)
          s1_bias[l*W +: W] <= bias_mem[grp][l];
      end
    end
  end

  for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
    bias_lane_sat #(.W(W)) u_lane (
      .a   (s1_data[i*W +: W]),
      .b   (s1_bias[i*W +: W]),
      .sum (sum[i*W +: W]),
      .sat (sat[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
      out_group <= '0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data  <= sum;
        out_sat   <= sat;
        out_group <= s1_grp;
      end
    end
  end

endmodule

// File: tb/tb_bias_add_stage.sv
// Directed-vector bench for bias_add_stage with hand-computed expectations.
module tb_bias_add_stage;

  localparam int NA = 16;
  localparam int W  = 18;
  localparam int NG = 8;
  localparam int GW = 3;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            bias_wr_en;
  logic [GW-1:0]   bias_wr_group;
  logic [LW-1:0]   bias_wr_lane;
  logic [W-1:0]    bias_wr_data;
  logic            grp_restart;
  logic            in_valid;
  logic            in_ready;
  logic [NA*W-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [NA*W-1:0] out_data;
  logic [NA-1:0]   out_sat;
  logic [GW-1:0]   out_group;

  bias_add_stage #(.N_adder_tree(NA), .W(W), .N_GROUPS(NG)) dut (
    .clk           (clk),
    .rst           (rst),
    .bias_wr_en    (bias_wr_en),
    .bias_wr_group (bias_wr_group),
    .bias_wr_lane  (bias_wr_lane),
    .bias_wr_data  (bias_wr_data),
    .grp_restart   (grp_restart),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_sat       (out_sat),
    .out_group     (out_group)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lane(input logic [NA*W-1:0] v, input int i);
    return 32'(v[i*W +: W]);
  endfunction

  task automatic wr(input int g, input int l, input logic [W-1:0] d);
    bias_wr_en    = 1'b1;
    bias_wr_group = GW'(g);
    bias_wr_lane  = LW'(l);
    bias_wr_data  = d;
    tick();
    bias_wr_en    = 1'b0;
  endtask

  task automatic send(input logic [NA*W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic restart();
    grp_restart = 1'b1;
    tick();
    grp_restart = 1'b0;
  endtask

  logic [W-1:0]  q_l0[$];
  logic [W-1:0]  q_l5[$];
  logic [GW-1:0] q_grp[$];

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      q_l0.push_back(out_data[0 +: W]);
      q_l5.push_back(out_data[5*W +: W]);
      q_grp.push_back(out_group);
    end
  end

  task automatic clear_q();
    q_l0.delete();
    q_l5.delete();
    q_grp.delete();
  endtask

  initial begin
    logic [NA*W-1:0] d;
    logic [W-1:0]    held_l0;
    logic [GW-1:0]   held_g;
    logic            acc, held;
    int              sent;
    int              n;
    logic            pat [6];
    int              exp_rg [6];

    rst = 1'b1; bias_wr_en = 1'b0; bias_wr_group = '0; bias_wr_lane = '0;
    bias_wr_data = '0; grp_restart = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // reset state
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_group", 32'(out_group), 0);
    check("rst_out_data0", lane(out_data, 0), 0);
    check("rst_out_sat", 32'(out_sat), 0);

    // basic bias add and latency
    for (int i = 0; i < NA; i++) wr(0, i, W'(4 * i));
    d = '0;
    for (int i = 0; i < NA; i++) d[i*W +: W] = W'(100);
    send(d);
    check("lat_early_valid", 32'(out_valid), 0);
    tick();
    check("lat_valid", 32'(out_valid), 1);
    for (int i = 0; i < NA; i++)
      check($sformatf("basic_lane%0d", i), lane(out_data, i), 32'(100 + 4 * i));
    check("basic_sat", 32'(out_sat), 0);
    check("basic_group", 32'(out_group), 0);
    tick();
    check("basic_bubble", 32'(out_valid), 0);

    // saturation at both ends
    restart();
    wr(0, 0, 18'h1FFF0);
    wr(0, 1, 18'h20000);
    d = '0;
    d[0 +: W] = 18'h00100;
    d[W +: W] = 18'h3FFFF;
    send(d);
    tick();
    check("sat_pos_lane0", lane(out_data, 0), 32'h1FFFF);
    check("sat_neg_lane1", lane(out_data, 1), 32'h20000);
    check("sat_flags", 32'(out_sat), 32'h3);
    check("sat_lane2", lane(out_data, 2), 8);
    check("sat_lane15", lane(out_data, 15), 60);
    wr(0, 0, '0);
    wr(0, 1, '0);

    // group wrap over 10 beats
    restart();
    clear_q();
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = '0;
      in_data[0 +: W] = W'(k);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("wrap_count", 32'(q_grp.size()), 10);
    n = (q_grp.size() < 10) ? q_grp.size() : 10;
    for (int k = 0; k < n; k++) begin
      check($sformatf("wrap_grp%0d", k), 32'(q_grp[k]), 32'(k % 8));
      check($sformatf("wrap_data%0d", k), 32'(q_l0[k]), 32'(k));
    end

    // restart coincident with the 4th accept
    restart();
    clear_q();
    exp_rg = '{0, 1, 2, 3, 0, 1};
    for (int k = 0; k < 6; k++) begin
      in_valid    = 1'b1;
      in_data     = '0;
      grp_restart = (k == 3);
      tick();
    end
    in_valid = 1'b0; grp_restart = 1'b0;
    tick(); tick(); tick();
    check("rst_grp_count", 32'(q_grp.size()), 6);
    n = (q_grp.size() < 6) ? q_grp.size() : 6;
    for (int k = 0; k < n; k++)
      check($sformatf("restart_grp%0d", k), 32'(q_grp[k]), 32'(exp_rg[k]));

    // backpressure: out_ready 1,0,0,1,0,1 repeating
    restart();
    clear_q();
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready = pat[c % 6];
      in_valid  = (sent < 6);
      in_data   = '0;
      in_data[0 +: W] = W'(1000 + sent);
      #1;
      acc     = in_valid && in_ready;
      held    = out_valid && !out_ready;
      held_l0 = out_data[0 +: W];
      held_g  = out_group;
      tick();
      if (acc) sent++;
      if (held) begin
        check("bp_hold_valid", 32'(out_valid), 1);
        check("bp_hold_data", lane(out_data, 0), 32'(held_l0));
        check("bp_hold_group", 32'(out_group), 32'(held_g));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick(); tick();
    check("bp_count", 32'(q_l0.size()), 6);
    n = (q_l0.size() < 6) ? q_l0.size() : 6;
    for (int k = 0; k < n; k++) begin
      check($sformatf("bp_data%0d", k), 32'(q_l0[k]), 32'(1000 + k));
      check($sformatf("bp_grp%0d", k), 32'(q_grp[k]), 32'(k));
    end

    // write collides with an accepted beat of the same group
    restart();
    wr(2, 5, W'(10));
    clear_q();
    send('0);
    send('0);
    in_valid      = 1'b1;
    in_data       = '0;
    bias_wr_en    = 1'b1;
    bias_wr_group = 3'd2;
    bias_wr_lane  = 4'd5;
    bias_wr_data  = W'(50);
    tick();
    in_valid   = 1'b0;
    bias_wr_en = 1'b0;
    restart();
    send('0);
    send('0);
    send('0);
    tick(); tick(); tick();
    check("coll_count", 32'(q_l5.size()), 6);
    if (q_l5.size() >= 6) begin
      check("coll_g0_lane5", 32'(q_l5[0]), 20);
      check("coll_old_grp", 32'(q_grp[2]), 2);
      check("coll_old_lane5", 32'(q_l5[2]), 10);
      check("coll_new_grp", 32'(q_grp[5]), 2);
      check("coll_new_lane5", 32'(q_l5[5]), 50);
    end

    // reset with two beats in flight
    wr(0, 0, W'(7));
    restart();
    in_valid = 1'b1;
    in_data  = '0;
    in_data[0 +: W] = W'(5);
    tick(); tick();
    in_valid = 1'b0;
    rst = 1'b1;
    clear_q();
    tick();
    rst = 1'b0;
    check("mid_rst_valid0", 32'(out_valid), 0);
    tick();
    check("mid_rst_valid1", 32'(out_valid), 0);
    tick();
    check("mid_rst_valid2", 32'(out_valid), 0);
    check("mid_rst_no_stale", 32'(q_l0.size()), 0);
    d = '0;
    d[0 +: W] = W'(5);
    send(d);
    tick();
    check("post_rst_valid", 32'(out_valid), 1);
    check("post_rst_lane0", lane(out_data, 0), 5);
    check("post_rst_lane5", lane(out_data, 5), 0);
    check("post_rst_group", 32'(out_group), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
